// File: rtl/status_led_pkg.sv
// Shared mode encodings and the per-channel output selector for the status LED bank.
package status_led_pkg;

    localparam logic [1:0] MODE_LEVEL   = 2'b00;
    localparam logic [1:0] MODE_STRETCH = 2'b01;
    localparam logic [1:0] MODE_STICKY  = 2'b10;
    localparam logic [1:0] MODE_BLINK   = 2'b11;

    function automatic logic led_mode_sel(
        input logic [1:0] mode,
        input logic       ev,
        input logic       stretch_act,
        input logic       sticky,
        input logic       blink_ph
    );
        logic val;
        val = 1'b0;
        case (mode)
            MODE_LEVEL:   val = ev;
            MODE_STRETCH: val = stretch_act;
            MODE_STICKY:  val = sticky | ev;
            MODE_BLINK:   val = stretch_act & blink_ph;
            default:      val = 1'b0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/status_led_channel.sv
// One LED channel: retriggerable stretch counter plus sticky latch, both always running,
// with the mode only choosing which view drives the logical LED value.
module status_led_channel
    import status_led_pkg::*;
#(
    parameter int STRETCH_W = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev,
    input  logic [1:0] mode,
    input  logic       clr_sticky,
    input  logic       blink_ph,
    output logic       led_val
);

    localparam logic [STRETCH_W-1:0] CNT_ONE = 1;

    logic [STRETCH_W-1:0] cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;
    logic                 stretch_act;

    always_comb begin
        cnt_d = cnt_q;
        if (ev) begin
            cnt_d = '1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Set dominates clear when both arrive in the same cycle.
    always_comb begin
        sticky_d = sticky_q;
        if (ev) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign stretch_act = ev | (cnt_q != '0);
    assign led_val     = led_mode_sel(mode, ev, stretch_act, sticky_q, blink_ph);

endmodule

// File: rtl/status_led_controller.sv
// N-channel status LED controller: per-channel mode logic, free-running heartbeat,
// lamp test override and board polarity on the registered LED pins.
module status_led_controller
    import status_led_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int STRETCH_W  = 23,
    parameter int HB_W       = 24,
    parameter int BLINK_BIT  = 21,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ev,
    input  logic [2*NUM_CH-1:0] ch_mode,
    input  logic [NUM_CH-1:0]   clr_sticky,
    input  logic                lamp_test,
    output logic [NUM_CH-1:0]   led,
    output logic                hb_out
);

    localparam logic            POL    = (ACTIVE_LOW != 0);
    localparam logic [HB_W-1:0] HB_ONE = 1;

    logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
    logic [NUM_CH-1:0] led_q, led_d;
    logic [NUM_CH-1:0] ch_val;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        status_led_channel #(
            .STRETCH_W (STRETCH_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .ev         (ev[i]),
            .mode       (ch_mode[2*i +: 2]),
            .clr_sticky (clr_sticky[i]),
            .blink_ph   (hb_cnt_q[BLINK_BIT]),
            .led_val    (ch_val[i])
        );
    end

    // Lamp test only masks the output register; channel state keeps evolving underneath.
    always_comb begin
        hb_cnt_d = hb_cnt_q + HB_ONE;
        led_d    = lamp_test ? '1 : ch_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
            led_q    <= '0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            led_q    <= led_d;
        end
    end

    assign led    = led_q ^ {NUM_CH{POL}};
    assign hb_out = hb_cnt_q[HB_W-1] ^ POL;

endmodule

// File: tb/tb_status_led_controller.sv
// Directed bench for status_led_controller: an active-high and an active-low instance
// share one stimulus stream; expected pin values are hand-computed per step.
module tb_status_led_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] ev;
    logic [7:0] ch_mode;
    logic [3:0] clr_sticky;
    logic       lamp_test;
    logic [3:0] led0, led1;
    logic       hb0, hb1;

    int total_cnt = 0;
    int bad_cnt   = 0;

    status_led_controller #(
        .NUM_CH(4), .STRETCH_W(4), .HB_W(6), .BLINK_BIT(2), .ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .ev(ev), .ch_mode(ch_mode),
        .clr_sticky(clr_sticky), .lamp_test(lamp_test), .led(led0), .hb_out(hb0)
    );

    status_led_controller #(
        .NUM_CH(4), .STRETCH_W(4), .HB_W(6), .BLINK_BIT(2), .ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .rst_n(rst_n), .ev(ev), .ch_mode(ch_mode),
        .clr_sticky(clr_sticky), .lamp_test(lamp_test), .led(led1), .hb_out(hb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ev         = 4'hF;
        lamp_test  = 1'b1;
        ch_mode    = 8'h00;
        clr_sticky = 4'h0;

        // Reset dominates events and lamp test
        repeat (3) tick();
        check_eq("rst_led", led0, 4'h0);
        check_eq("rst_hb", hb0, 1'b0);
        check_eq("rst_led_al", led1, 4'hF);
        check_eq("rst_hb_al", hb1, 1'b1);

        ev = 4'h0; lamp_test = 1'b0; rst_n = 1'b1;
        repeat (31) tick();
        check_eq("hb_31", hb0, 1'b0);
        tick();
        check_eq("hb_32", hb0, 1'b1);
        check_eq("hb_32_al", hb1, 1'b0);
        repeat (31) tick();
        check_eq("hb_63", hb0, 1'b1);
        tick();
        check_eq("hb_wrap", hb0, 1'b0);

        // Heartbeat counter is now 0: ch2 BLINK with ev held, ch3 LEVEL
        ch_mode = 8'h30; ev = 4'b1100;
        for (int e = 1; e <= 13; e++) begin
            if (e == 6) ev = 4'b0100;
            tick();
            case (e)
                1:  check_eq("blink_e1", led0, 4'b1000);
                5:  check_eq("blink_e5", led0, 4'b1100);
                6:  check_eq("level_drop", led0, 4'b0100);
                9:  check_eq("blink_e9", led0, 4'b0000);
                13: check_eq("blink_e13", led0, 4'b0100);
                default: ;
            endcase
        end

        ev = 4'h0; ch_mode = 8'h01;
        repeat (20) tick();
        check_eq("idle", led0, 4'h0);

        // Single-pulse stretch on ch0: lit for 16 cycles
        ev = 4'h1; tick(); ev = 4'h0;
        check_eq("str_first", led0, 4'h1);
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 15) check_eq("str_last", led0, 4'h1);
            if (e == 16) check_eq("str_off", led0, 4'h0);
        end

        // Retrigger ten cycles after the first pulse
        ev = 4'h1; tick(); ev = 4'h0;
        for (int e = 1; e <= 26; e++) begin
            ev = (e == 10) ? 4'h1 : 4'h0;
            tick();
            ev = 4'h0;
            if (e == 16) check_eq("retrig_hold", led0, 4'h1);
            if (e == 25) check_eq("retrig_last", led0, 4'h1);
            if (e == 26) check_eq("retrig_off", led0, 4'h0);
        end

        // Mode switch mid-stretch leaves the counter running
        ev = 4'h1; tick(); ev = 4'h0;
        for (int e = 1; e <= 16; e++) begin
            if (e == 8)  ch_mode = 8'h00;
            if (e == 11) ch_mode = 8'h01;
            tick();
            if (e == 8)  check_eq("sw_level", led0, 4'h0);
            if (e == 10) check_eq("sw_level2", led0, 4'h0);
            if (e == 11) check_eq("sw_back", led0, 4'h1);
            if (e == 15) check_eq("sw_last", led0, 4'h1);
            if (e == 16) check_eq("sw_off", led0, 4'h0);
        end

        // Sticky on ch1
        ch_mode = 8'h08; ev = 4'b0010; tick(); ev = 4'h0;
        check_eq("sticky_set", led0, 4'b0010);
        repeat (100) tick();
        check_eq("sticky_hold", led0, 4'b0010);
        ev = 4'b0010; clr_sticky = 4'b0010; tick();
        check_eq("sticky_both", led0, 4'b0010);
        ev = 4'h0; clr_sticky = 4'h0; tick();
        check_eq("sticky_set_wins", led0, 4'b0010);
        clr_sticky = 4'b0010; tick(); clr_sticky = 4'h0;
        tick();
        check_eq("sticky_clr", led0, 4'h0);
        tick();
        check_eq("sticky_clr_stay", led0, 4'h0);

        // Lamp test forces all on without disturbing the latch
        ev = 4'b0010; tick(); ev = 4'h0;
        lamp_test = 1'b1; tick();
        check_eq("lamp_on", led0, 4'hF);
        check_eq("lamp_on_al", led1, 4'h0);
        lamp_test = 1'b0; tick();
        check_eq("lamp_off", led0, 4'b0010);
        check_eq("lamp_off_al", led1, 4'b1101);

        // Reset during stretch clears every channel
        ch_mode = 8'h55; ev = 4'hF; tick(); ev = 4'h0; tick();
        check_eq("pre_rst", led0, 4'hF);
        check_eq("pre_rst_al", led1, 4'h0);
        rst_n = 1'b0; tick();
        check_eq("mid_rst", led0, 4'h0);
        check_eq("mid_rst_al", led1, 4'hF);
        check_eq("mid_rst_hb", hb0, 1'b0);
        rst_n = 1'b1; tick();
        check_eq("post_rst", led0, 4'h0);
        check_eq("post_rst_al", led1, 4'hF);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/status_led_controller.md
Name: status_led_controller

Overview:
Parametrised N-channel status indicator that drives the board LED bank from single-cycle or level event strobes such as sync_en, adc_valid/dac_valid, push_to_talk, rst and error flags. Each channel is independently mode-selectable at run time: direct level, retriggerable pulse stretch, sticky latch, or stretched blink. A free-running heartbeat, a lamp test and a board-polarity option are included. It replaces the ad-hoc stretchers and heartbeat counter in the top level with one reusable block on the system clock.

Parameters:
NUM_CH, 8, number of LED channels (1..32)
STRETCH_W, 23, width of the per-channel stretch counter; one pulse lights the LED for 2^STRETCH_W cycles
HB_W, 24, heartbeat counter width; hb_out = counter MSB
BLINK_BIT, 21, heartbeat counter bit that gates BLINK mode (must be < HB_W)
ACTIVE_LOW, 0, 1 = invert led and hb_out pins for active-low boards

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
ev  input  NUM_CH  per-channel event/level input, clk domain
ch_mode  input  2*NUM_CH  per-channel mode; channel i uses bits [2i+1:2i]
clr_sticky  input  NUM_CH  per-channel sticky-latch clear strobe
lamp_test  input  1  force all LEDs on while high
led  output  NUM_CH  registered LED drive, pin polarity per ACTIVE_LOW
hb_out  output  1  heartbeat, pin polarity per ACTIVE_LOW

Behaviour:
- Reset (rst_n=0 at a clk edge): all stretch counters = 0, sticky latches = 0, heartbeat counter = 0.
  - led = all logical-off: 0 when ACTIVE_LOW=0, all-ones when ACTIVE_LOW=1.
  - hb_out = logical 0.
  - Reset asserted mid-stretch or mid-blink clears the channel within one cycle.
- Heartbeat: hb_cnt increments by 1 every cycle and wraps at 2^HB_W-1 -> 0. hb_out is registered = hb_cnt MSB.
- Per-channel state updates every cycle regardless of the selected mode. A mode change therefore only alters the output selection; it never resets state.
- Stretch counter cnt (STRETCH_W bits):
  - ev=1: cnt <= all-ones. A retrigger reloads.
  - ev=0 and cnt!=0: cnt <= cnt-1.
  - otherwise cnt holds.
  - stretch_act = ev | (cnt!=0).
- Sticky latch: set when ev=1; cleared when clr_sticky=1 and ev=0. If ev and clr_sticky are asserted together, set wins.
- Mode encoding and the logical LED value computed from current-cycle inputs and state:
  - 00 LEVEL: ev
  - 01 STRETCH: stretch_act
  - 10 STICKY: sticky | ev
  - 11 BLINK: stretch_act & hb_cnt[BLINK_BIT]
- Output stage:
  - led_q <= lamp_test ? all-ones : logical value.
  - Pin = led_q XOR {NUM_CH{ACTIVE_LOW}}.
  - Latency is 1 cycle from ev, mode change or lamp_test to the led pin.
  - lamp_test does not disturb counters or latches.
- Timing: a single-cycle ev at cycle t (STRETCH mode) drives led on for exactly cycles t+1 .. t+2^STRETCH_W.

Decomposition:
- Package status_led_pkg holds:
  - mode localparams MODE_LEVEL=2'b00, MODE_STRETCH=2'b01, MODE_STICKY=2'b10, MODE_BLINK=2'b11.
  - function led_mode_sel(mode, ev, stretch_act, sticky, blink_ph).
- Sub-module status_led_channel (parameter STRETCH_W): holds cnt and the sticky latch, and outputs the logical LED value. It is instantiated NUM_CH times by a generate loop.
- Top holds the heartbeat counter, lamp_test override and polarity stage.

Test Plan:
All scenarios use NUM_CH=4, STRETCH_W=4, HB_W=6, BLINK_BIT=2, ACTIVE_LOW=0 unless stated.
1. Reset: hold rst_n=0 with ev=4'hF and lamp_test=1 -> led=4'h0 and hb_out=0. Release, then 32 cycles -> hb_out=1; after 64 cycles it wraps to 0.
2. STRETCH: ch0 mode 01, 1-cycle ev at t -> led[0]=1 for exactly cycles t+1..t+16, 0 at t+17. Retrigger at t+10 -> led[0] stays 1 through t+26.
3. STICKY: ch1 mode 10. Pulse ev -> led[1] stays 1 for 100 cycles. clr_sticky and ev together -> still 1. clr_sticky alone -> led[1]=0 next cycle.
4. BLINK and LEVEL: ch2 mode 11 with ev held 1 -> led[2] toggles every 4 cycles in phase with hb_cnt[2]. ch3 mode 00 -> led[3] follows ev delayed by 1 cycle.
5. Mode switch mid-stretch: ch0 stretching, switch mode 01->00 at cnt=8 -> led[0]=0. Switch back at cnt=5 -> led[0]=1 until cnt reaches 0.
6. ACTIVE_LOW=1: after reset led=4'hF. lamp_test=1 -> led=4'h0 next cycle. Reset during stretch -> led=4'hF next cycle.
